// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive FIFO.
package uart_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int RTS_HI_DEF = 12;
    localparam int RTS_LO_DEF = 8;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } rts_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the receive FIFO: one clocked write port, one combinational read port.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  rx_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output rx_entry_t                rdata
);

    // Contents are deliberately left unreset; validity is tracked by the FIFO level.
    rx_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: frame-strobe detection, show-ahead read,
// sticky overrun flag and hysteretic RTS flow control.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RTS_HI = RTS_HI_DEF,
    parameter int RTS_LO = RTS_LO_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   parity_error,
    input  logic                   rd_en,
    input  logic                   flush,
    input  logic                   clr_overrun,
    output logic [7:0]             rd_data,
    output logic                   rd_perr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    output logic                   rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_HI   = LW'(RTS_HI);
    localparam logic [LW-1:0] LVL_LO   = LW'(RTS_LO);

    logic          rx_done_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    rts_state_e    rts_q, rts_d;

    logic          push, pop, wr_en, drop, is_full, is_empty;
    rx_entry_t     wr_entry, head;

    assign is_full  = (level_q == LVL_FULL);
    assign is_empty = (level_q == '0);
    assign push     = rx_done & ~rx_done_q;
    assign pop      = rd_en & ~is_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en    = push & (~is_full | pop);
    assign drop     = push & is_full & ~pop & ~flush;
    assign wr_entry = '{perr: parity_error, data: rx_data};

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Hysteresis between the two thresholds keeps rts_n from chattering around one level.
    always_comb begin
        rts_d = rts_q;
        if (flush) begin
            rts_d = RUN;
        end else begin
            case (rts_q)
                RUN:     if (level_q >= LVL_HI) rts_d = HOLD;
                HOLD:    if (level_q <= LVL_LO) rts_d = RUN;
                default: rts_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= RUN;
        end else begin
            rx_done_q <= rx_done;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
        end
    end

    assign rd_data = head.data;
    assign rd_perr = head.perr;
    assign empty   = is_empty;
    assign full    = is_full;
    assign level   = level_q;
    assign overrun = overrun_q;
    assign rts_n   = (rts_q == HOLD);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run
// compared against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int RTS_HI = 12;
    localparam int RTS_LO = 8;

    logic       clk = 1'b0;
    logic       reset_n, rx_done, parity_error, rd_en, flush, clr_overrun;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       rd_perr, empty, full, overrun, rts_n;
    logic [4:0] level;

    logic       r_reset_n, r_rx_done, r_parity_error, r_rd_en, r_flush, r_clr_overrun;
    logic [7:0] r_rx_data;
    logic [7:0] r_rd_data;
    logic       r_rd_perr, r_empty, r_full, r_overrun, r_rts_n;
    logic [3:0] r_level;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] modelQ[$];
    bit         modelOvr, modelHold, modelRxdPrev;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .parity_error(parity_error), .rd_en(rd_en), .flush(flush),
        .clr_overrun(clr_overrun), .rd_data(rd_data), .rd_perr(rd_perr),
        .empty(empty), .full(full), .level(level), .overrun(overrun), .rts_n(rts_n)
    );

    uart_rx_fifo #(.DEPTH(8), .RTS_HI(4), .RTS_LO(2)) dut_r (
        .clk(clk), .reset_n(r_reset_n), .rx_data(r_rx_data), .rx_done(r_rx_done),
        .parity_error(r_parity_error), .rd_en(r_rd_en), .flush(r_flush),
        .clr_overrun(r_clr_overrun), .rd_data(r_rd_data), .rd_perr(r_rd_perr),
        .empty(r_empty), .full(r_full), .level(r_level), .overrun(r_overrun), .rts_n(r_rts_n)
    );

    // One clock of the main DUT, with the model advanced from the same inputs.
    task automatic step();
        bit push, pop, drop;
        int sz;
        @(posedge clk);
        sz = modelQ.size();
        push = rx_done && !modelRxdPrev;
        modelRxdPrev = rx_done;
        if (flush) begin
            modelQ.delete();
            modelHold = 1'b0;
            if (clr_overrun) modelOvr = 1'b0;
        end else begin
            pop  = rd_en && (sz > 0);
            drop = push && (sz == DEPTH) && !pop;
            if (!modelHold && sz >= RTS_HI) modelHold = 1'b1;
            else if (modelHold && sz <= RTS_LO) modelHold = 1'b0;
            if (drop) modelOvr = 1'b1;
            else if (clr_overrun) modelOvr = 1'b0;
            if (pop) void'(modelQ.pop_front());
            if (push && !drop) modelQ.push_back({parity_error, rx_data});
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic rd, input logic clr);
        rx_done = 1'b0;
        rx_data = d;
        parity_error = pe;
        step();
        rx_done = 1'b1;
        rd_en = rd;
        clr_overrun = clr;
        step();
        rd_en = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic read_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_done = 1'b1; rx_data = 8'h00; parity_error = 1'b0;
        rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
        modelQ.delete(); modelOvr = 1'b0; modelHold = 1'b0; modelRxdPrev = 1'b1;
        #12 reset_n = 1'b1;
        step();
        step();
        vectors++; if (empty !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_empty: got %0b want 1", empty); end
        vectors++; if (full !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_full: got %0b want 0", full); end
        vectors++; if (level !== 5'd0)   begin miscompares++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %0b want 0", overrun); end
        vectors++; if (rts_n !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_rts_n: got %0b want 0", rts_n); end
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        vectors++; if (empty !== 1'b0)     begin miscompares++; $display("[TB] FAIL single_empty: got %0b want 0", empty); end
        vectors++; if (level !== 5'd1)     begin miscompares++; $display("[TB] FAIL single_level: got %0d want 1", level); end
        vectors++; if (rd_data !== 8'hA5)  begin miscompares++; $display("[TB] FAIL single_data: got %02h want a5", rd_data); end
        vectors++; if (rd_perr !== 1'b0)   begin miscompares++; $display("[TB] FAIL single_perr: got %0b want 0", rd_perr); end
        read_one();
        vectors++; if (empty !== 1'b1)     begin miscompares++; $display("[TB] FAIL single_pop_empty: got %0b want 1", empty); end
    endtask

    task automatic test_empty_pop();
        read_one();
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL empty_pop_level: got %0d want 0", level); end
        send_frame(8'h6E, 1'b0, 1'b1, 1'b0);
        vectors++; if (level !== 5'd1)    begin miscompares++; $display("[TB] FAIL empty_pushpop_level: got %0d want 1", level); end
        vectors++; if (rd_data !== 8'h6E) begin miscompares++; $display("[TB] FAIL empty_pushpop_data: got %02h want 6e", rd_data); end
        read_one();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        vectors++; if (full !== 1'b1)    begin miscompares++; $display("[TB] FAIL fill_full: got %0b want 1", full); end
        vectors++; if (level !== 5'd16)  begin miscompares++; $display("[TB] FAIL fill_level: got %0d want 16", level); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_overrun: got %0b want 1", overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (rd_data !== 8'(i)) begin miscompares++; $display("[TB] FAIL fill_read%0d: got %02h want %02h", i, rd_data, 8'(i)); end
            read_one();
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_drained: got %0b want 1 (0xFF should be absent)", empty); end
    endtask

    task automatic test_parity_flush();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        vectors++; if (rd_perr !== 1'b1)  begin miscompares++; $display("[TB] FAIL parity_perr: got %0b want 1", rd_perr); end
        vectors++; if (rd_data !== 8'h55) begin miscompares++; $display("[TB] FAIL parity_data: got %02h want 55", rd_data); end
        rx_done = 1'b0; rx_data = 8'h99; parity_error = 1'b0;
        step();
        rx_done = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (level !== 5'd0)   begin miscompares++; $display("[TB] FAIL flush_level: got %0d want 0", level); end
        vectors++; if (empty !== 1'b1)   begin miscompares++; $display("[TB] FAIL flush_empty: got %0b want 1", empty); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_overrun_kept: got %0b want 1", overrun); end
        step();
        vectors++; if (level !== 5'd0)   begin miscompares++; $display("[TB] FAIL flush_no_late_push: got %0d want 0", level); end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < RTS_HI; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        vectors++; if (level !== 5'd12) begin miscompares++; $display("[TB] FAIL hyst_level12: got %0d want 12", level); end
        vectors++; if (rts_n !== 1'b0)  begin miscompares++; $display("[TB] FAIL hyst_rts_lag: got %0b want 0", rts_n); end
        step();
        vectors++; if (rts_n !== 1'b1)  begin miscompares++; $display("[TB] FAIL hyst_rts_hold: got %0b want 1", rts_n); end
        for (int i = 0; i < 3; i++) read_one();
        step();
        vectors++; if (level !== 5'd9)  begin miscompares++; $display("[TB] FAIL hyst_level9: got %0d want 9", level); end
        vectors++; if (rts_n !== 1'b1)  begin miscompares++; $display("[TB] FAIL hyst_rts_at9: got %0b want 1", rts_n); end
        read_one();
        vectors++; if (level !== 5'd8)  begin miscompares++; $display("[TB] FAIL hyst_level8: got %0d want 8", level); end
        step();
        vectors++; if (rts_n !== 1'b0)  begin miscompares++; $display("[TB] FAIL hyst_rts_run: got %0b want 0", rts_n); end
        for (int i = 0; i < 8; i++) read_one();
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        vectors++; if (level !== 5'd16)  begin miscompares++; $display("[TB] FAIL pp_full_level: got %0d want 16", level); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL pp_full_overrun: got %0b want 0", overrun); end
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL set_beats_clr: got %0b want 1", overrun); end
        for (int i = 1; i < DEPTH; i++) begin
            vectors++;
            if (rd_data !== 8'(8'h10 + i)) begin miscompares++; $display("[TB] FAIL pp_read%0d: got %02h want %02h", i, rd_data, 8'(8'h10 + i)); end
            read_one();
        end
        vectors++; if (rd_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL pp_last: got %02h want 3c", rd_data); end
        read_one();
        vectors++; if (empty !== 1'b1)    begin miscompares++; $display("[TB] FAIL pp_drained: got %0b want 1", empty); end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
    endtask

    task automatic test_random();
        int rdPct;
        for (int c = 0; c < 1200; c++) begin
            rdPct = ((c / 150) % 2 == 0) ? 10 : 60;
            rx_done      = ($urandom_range(0, 2) != 0);
            rx_data      = 8'($urandom);
            parity_error = 1'($urandom);
            rd_en        = ($urandom_range(0, 99) < rdPct);
            flush        = ($urandom_range(0, 199) == 0);
            clr_overrun  = ($urandom_range(0, 39) == 0);
            step();
            vectors++; if (level !== 5'(modelQ.size())) begin miscompares++; $display("[TB] FAIL rnd_level c%0d: got %0d want %0d", c, level, modelQ.size()); end
            vectors++; if (empty !== (modelQ.size() == 0)) begin miscompares++; $display("[TB] FAIL rnd_empty c%0d: got %0b want %0b", c, empty, modelQ.size() == 0); end
            vectors++; if (full !== (modelQ.size() == DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_full c%0d: got %0b want %0b", c, full, modelQ.size() == DEPTH); end
            vectors++; if (overrun !== modelOvr) begin miscompares++; $display("[TB] FAIL rnd_overrun c%0d: got %0b want %0b", c, overrun, modelOvr); end
            vectors++; if (rts_n !== modelHold) begin miscompares++; $display("[TB] FAIL rnd_rts_n c%0d: got %0b want %0b", c, rts_n, modelHold); end
            if (modelQ.size() > 0) begin
                vectors++;
                if ({rd_perr, rd_data} !== modelQ[0]) begin miscompares++; $display("[TB] FAIL rnd_head c%0d: got %03h want %03h", c, {rd_perr, rd_data}, modelQ[0]); end
            end
        end
        rx_done = 1'b1; rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    endtask

    task automatic test_reset_mid();
        r_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r_rx_done = 1'b0; r_rx_data = 8'(8'hC0 + i);
            @(posedge clk); #1;
            r_rx_done = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        vectors++; if (r_level !== 4'd5) begin miscompares++; $display("[TB] FAIL rmid_level5: got %0d want 5", r_level); end
        vectors++; if (r_rts_n !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_rts_hold: got %0b want 1", r_rts_n); end
        #1 r_reset_n = 1'b0;
        #1;
        vectors++; if (r_level !== 4'd0)   begin miscompares++; $display("[TB] FAIL rmid_async_level: got %0d want 0", r_level); end
        vectors++; if (r_empty !== 1'b1)   begin miscompares++; $display("[TB] FAIL rmid_async_empty: got %0b want 1", r_empty); end
        vectors++; if (r_rts_n !== 1'b0)   begin miscompares++; $display("[TB] FAIL rmid_async_rts: got %0b want 0", r_rts_n); end
        vectors++; if (r_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_async_overrun: got %0b want 0", r_overrun); end
        #2 r_reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (r_level !== 4'd0) begin miscompares++; $display("[TB] FAIL rmid_no_push: got %0d want 0", r_level); end
        vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_no_push_empty: got %0b want 1", r_empty); end
    endtask

    initial begin
        r_reset_n = 1'b0; r_rx_done = 1'b1; r_rx_data = 8'h00; r_parity_error = 1'b0;
        r_rd_en = 1'b0; r_flush = 1'b0; r_clr_overrun = 1'b0;
        test_reset();
        r_reset_n = 1'b1;
        test_single_frame();
        test_empty_pop();
        test_fill();
        test_parity_flush();
        test_hysteresis();
        test_push_pop_full();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
